// File: rtl/ram_256x8.sv
// rtl/ram_256x8.sv - single-port synchronous 256x8 RAM with chip select and tri-state read bus
// Write-first registered read port; the bus is released whenever CS is low.
module ram_256x8 #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic                  W_R,
  input  logic [DATA_WIDTH-1:0] Data_in,
  input  logic                  CS,
  output wire  [DATA_WIDTH-1:0] Data_out
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0] rd_d;
  logic                  wr_en;

  // Only a definite 1 on W_R writes; anything else is treated as a read.
  always_comb begin
    wr_en = 1'b0;
    rd_d  = rd_q;
    if (CS) begin
      if (W_R == 1'b1) begin
        wr_en = 1'b1;
        rd_d  = Data_in;
      end else begin
        rd_d  = mem_q[Address];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_q <= '0;
    end else begin
      if (wr_en) begin
        mem_q[Address] <= Data_in;
      end
      rd_q <= rd_d;
    end
  end

  // Bus drive follows CS combinationally, independent of clock and reset.
  assign Data_out = CS ? rd_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_ram_256x8.sv
// tb/tb_ram_256x8.sv - directed self-checking bench for ram_256x8
// A second bus device drives 8'h5A whenever the RAM is deselected.
module tb_ram_256x8;

  logic       clk;
  logic       rst_n;
  logic [7:0] address;
  logic       w_r;
  logic [7:0] data_in;
  logic       cs;
  wire  [7:0] bus;

  int n_tests;
  int n_fail;

  localparam logic [7:0] OTHER = 8'h5A;

  ram_256x8 dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .Address  (address),
    .W_R      (w_r),
    .Data_in  (data_in),
    .CS       (cs),
    .Data_out (bus)
  );

  assign bus = cs ? 8'hzz : OTHER;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    cs = 1'b1; w_r = 1'b1; address = a; data_in = d;
    tick();
  endtask

  task automatic rd(input logic [7:0] a);
    cs = 1'b1; w_r = 1'b0; address = a; data_in = 8'h2A;
    tick();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0; cs = 1'b1; w_r = 1'b0; address = 8'h0D; data_in = 8'h00;
    tick();
    chk("reset_rdq", bus, 8'h00);
    rst_n = 1'b1;
    rd(8'h0D); chk("reset_rd_0d", bus, 8'h00);
    rd(8'hFF); chk("reset_rd_ff", bus, 8'h00);
    rd(8'h80); chk("reset_rd_80", bus, 8'h00);

    cs = 1'b0; w_r = 1'b0; address = 8'h00;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("desel_hiz", bus, OTHER);
    end
    cs = 1'b1; #1;
    chk("resel_hold0", bus, 8'h00);

    wr(8'h0D, 8'h3F); chk("wr_0d", bus, 8'h3F);
    wr(8'h05, 8'h03); chk("wr_05", bus, 8'h03);

    rd(8'h0D); chk("rd_0d", bus, 8'h3F);
    rd(8'h05); chk("rd_05", bus, 8'h03);
    rd(8'h0D); chk("rd_0d_again", bus, 8'h3F);
    rd(8'h05); chk("rd_05_again", bus, 8'h03);

    cs = 1'b0; #1;
    chk("cs_drop", bus, OTHER);
    cs = 1'b1; #1;
    chk("cs_raise", bus, 8'h03);

    cs = 1'b0; w_r = 1'b1; address = 8'h05; data_in = 8'h77;
    tick();
    chk("desel_wr_bus", bus, OTHER);
    cs = 1'b1; #1;
    chk("desel_rdq_hold", bus, 8'h03);
    rd(8'h05); chk("desel_no_write", bus, 8'h03);

    wr(8'h10, 8'hC3);
    rd(8'h10); chk("wr_then_rd", bus, 8'hC3);
    wr(8'h00, 8'h81);
    rd(8'h00); chk("addr_00", bus, 8'h81);

    wr(8'hFF, 8'hA5); chk("wr_ff", bus, 8'hA5);
    rst_n = 1'b0;
    wr(8'hFF, 8'h11);
    chk("rst_over_wr", bus, 8'h00);
    rst_n = 1'b1;
    rd(8'hFF); chk("rst_ff", bus, 8'h00);
    rd(8'h0D); chk("rst_0d", bus, 8'h00);
    rd(8'h10); chk("rst_10", bus, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
